// File: rtl/data_distributor_if.sv
// Bundles the producer-side and consumer-side signals of data_distributor.
// master: the environment (producer + consumers); slave: the distributor itself.
interface data_distributor_if #(
   parameter int W  = 8,
   parameter int N  = 2,
   parameter int CW = 8
);
   localparam int SW = $clog2(N + 1);

   logic [W-1:0]   in_data;
   logic [SW-1:0]  sel;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] q;
   logic [N-1:0]   out_valid;
   logic [N-1:0]   out_ready;
   logic           err;
   logic [CW-1:0]  drop_cnt;

   modport master (
      output in_data, sel, in_valid, out_ready,
      input  in_ready, q, out_valid, err, drop_cnt
   );

   modport slave (
      input  in_data, sel, in_valid, out_ready,
      output in_ready, q, out_valid, err, drop_cnt
   );
endinterface

// File: rtl/data_distributor.sv
// Registered 1-to-N demultiplexer with a one-entry valid/ready register per
// output channel. Words whose sel is out of range are discarded, flagged by a
// one-cycle err pulse and counted in a saturating drop counter.
// Optional feature macro: DATA_DISTRIBUTOR_BROADCAST_EN -- when defined,
// sel == N loads every channel at once; otherwise sel == N is dropped.
module data_distributor #(
   parameter int W  = 8,
   parameter int N  = 2,
   parameter int CW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   data_distributor_if.slave bus
);
   localparam int SW = $clog2(N + 1);

   logic [N-1:0]  ch_free;
   logic [N-1:0]  sel_hit;
   logic [N-1:0]  load;
   logic [N-1:0]  valid_reg;
   logic [W-1:0]  q_reg [N];
   logic          sel_in_range;
   logic          bcast;
   logic          sel_free;
   logic          all_free;
   logic          in_ready_int;
   logic          accept;
   logic          drop;
   logic          err_reg;
   logic [CW-1:0] drop_cnt_reg;
   logic [CW-1:0] drop_cnt_next;

   assign sel_in_range = (bus.sel < SW'(N));

`ifdef DATA_DISTRIBUTOR_BROADCAST_EN
   assign bcast = (bus.sel == SW'(N));
`else
   assign bcast = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ch
         assign sel_hit[gi] = (bus.sel == SW'(gi));
         // A channel can take a word if it is empty or is being drained now.
         assign ch_free[gi] = ~valid_reg[gi] | bus.out_ready[gi];
         assign load[gi]    = accept & (sel_hit[gi] | bcast);
         assign bus.q[gi*W +: W] = q_reg[gi];

         // Channel data register: only written on load, so it holds while stalled or idle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               q_reg[gi] <= '0;
            else if (load[gi])
               q_reg[gi] <= bus.in_data;
         end

         // Channel valid flag: a load wins over a simultaneous drain.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               valid_reg[gi] <= 1'b0;
            else if (load[gi])
               valid_reg[gi] <= 1'b1;
            else if (bus.out_ready[gi])
               valid_reg[gi] <= 1'b0;
         end
      end
   endgenerate

   assign sel_free = |(sel_hit & ch_free);
   assign all_free = &ch_free;

   // Input ready: depends only on sel and channel state; invalid sel always accepts.
   always_comb begin
      in_ready_int = 1'b1;
      if (sel_in_range)
         in_ready_int = sel_free;
      else if (bcast)
         in_ready_int = all_free;
   end

   assign accept       = bus.in_valid & in_ready_int;
   assign drop         = accept & ~sel_in_range & ~bcast;
   assign bus.in_ready = in_ready_int;
   assign bus.out_valid = valid_reg;

   // Drop counter increment that stops at all-ones instead of wrapping.
   always_comb begin
      drop_cnt_next = drop_cnt_reg;
      if (drop && (drop_cnt_reg != {CW{1'b1}}))
         drop_cnt_next = drop_cnt_reg + 1'b1;
   end

   // Error pulse and drop counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_reg      <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         err_reg      <= drop;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   assign bus.err      = err_reg;
   assign bus.drop_cnt = drop_cnt_reg;
endmodule
